// File: rtl/dmem_arbiter_if.sv
// Bundle of MEM-stage, external-requester and dmem signals
// around the shared data-memory port.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_mem_read;
  logic              core_mem_write;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_mem_read, core_mem_write,
    input  core_addr, core_wdata,
    output core_rdata, core_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_mem_read, core_mem_write,
    output core_addr, core_wdata,
    input  core_rdata, core_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Per-cycle arbiter for the single-port dmem shared by the
// core MEM stage and an external loader, with starvation bound.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CORE,
    OWN_EXT
  } owner_e;

  owner_e      owner_q;
  owner_e      owner_d;
  logic [7:0]  starve_cnt;
  logic [7:0]  starve_d;
  logic        rvalid_q;
  logic        core_req;
  logic        starve_hit;
  logic        ext_win;
  logic        core_win;

  always_comb begin
    core_req   = bus.core_mem_read
               | bus.core_mem_write;
    starve_hit = (starve_cnt == SMAX);
    ext_win    = !rst && bus.ext_req
              && (!core_req || starve_hit);
    core_win   = !rst && core_req && !ext_win;
  end

  // Port mux; a read+write core request drives as a store.
  always_comb begin
    owner_d        = OWN_IDLE;
    bus.ext_gnt    = 1'b0;
    bus.core_stall = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    unique case (1'b1)
      ext_win: begin
        owner_d        = OWN_EXT;
        bus.ext_gnt    = 1'b1;
        bus.core_stall = core_req;
        bus.mem_we     = bus.ext_we;
        bus.mem_addr   = bus.ext_addr;
        bus.mem_wdata  = bus.ext_wdata;
      end
      core_win: begin
        owner_d       = OWN_CORE;
        bus.mem_we    = bus.core_mem_write;
        bus.mem_addr  = bus.core_addr;
        bus.mem_wdata = bus.core_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (bus.ext_req && !ext_win) begin
      starve_d = starve_hit ? starve_cnt
                            : starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_IDLE;
      starve_cnt <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      starve_cnt <= starve_d;
      rvalid_q   <= bus.ext_gnt && !bus.ext_we;
    end
  end

  // Reset also kills a read return already in flight.
  assign bus.ext_rvalid = rvalid_q && !rst;
  assign bus.ext_rdata  = bus.mem_rdata;
  assign bus.core_rdata = bus.mem_rdata;

  a_rvalid_owner: assert property (
    @(posedge clk) disable iff (rst)
    bus.ext_rvalid |-> owner_q == OWN_EXT
  );

  a_starve_bound: assert property (
    @(posedge clk) disable iff (rst)
    starve_cnt <= SMAX
  );

  a_one_owner: assert property (
    @(posedge clk) disable iff (rst)
    !(ext_win && core_win)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural
// synchronous memory behind the shared port.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) begin
    if (bus.mem_we)
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic        ereq;
    logic        ewe;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic        gnt;
    logic        stall;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic drv(input logic rd, input logic wr,
                     input logic ereq, input logic ewe,
                     input logic [31:0] caddr,
                     input logic [31:0] cwdata,
                     input logic [31:0] eaddr,
                     input logic [31:0] ewdata);
    bus.core_mem_read  = rd;
    bus.core_mem_write = wr;
    bus.ext_req        = ereq;
    bus.ext_we         = ewe;
    bus.core_addr      = caddr;
    bus.core_wdata     = cwdata;
    bus.ext_addr       = eaddr;
    bus.ext_wdata      = ewdata;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'h0000CAFE;
    bus.mem_rdata = '0;

    vecs[0] = '{0,0,0,0, 0,0,0,0,
                0,0,0, 32'h0, 32'h0};
    vecs[1] = '{1,0,0,0, 32'h10,32'hAA,0,0,
                0,0,0, 32'h10, 32'hAA};
    vecs[2] = '{0,1,0,0, 32'h14,32'h77,0,0,
                0,0,1, 32'h14, 32'h77};
    vecs[3] = '{0,0,1,1, 0,0,32'h20,32'h1234,
                1,0,1, 32'h20, 32'h1234};
    vecs[4] = '{0,0,1,0, 0,0,32'h24,32'h99,
                1,0,0, 32'h24, 32'h99};
    vecs[5] = '{1,0,1,1, 32'h18,0,32'h28,32'h5,
                0,0,0, 32'h18, 32'h0};
    vecs[6] = '{1,1,0,0, 32'h40,32'h55,0,0,
                0,0,1, 32'h40, 32'h55};
    vecs[7] = '{0,1,1,0, 32'h1C,32'h66,32'h2C,0,
                0,0,1, 32'h1C, 32'h66};

    // Reset with both requesters active
    rst = 1'b1;
    drv(1, 1, 1, 1, 32'h44, 32'h11, 32'h48, 32'h22);
    #1;
    chk("rst_gnt",   32'(bus.ext_gnt),    0);
    chk("rst_stall", 32'(bus.core_stall), 0);
    chk("rst_we",    32'(bus.mem_we),     0);
    chk("rst_addr",  bus.mem_addr,        0);
    chk("rst_wdata", bus.mem_wdata,       0);
    tick();
    chk("rst_rvalid", 32'(bus.ext_rvalid), 0);
    chk("rst_starve", 32'(dut.starve_cnt), 0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Single-cycle grant table
    for (int i = 0; i < 8; i++) begin
      drv(vecs[i].rd, vecs[i].wr,
          vecs[i].ereq, vecs[i].ewe,
          vecs[i].caddr, vecs[i].cwdata,
          vecs[i].eaddr, vecs[i].ewdata);
      #1;
      chk($sformatf("v%0d_gnt", i),
          32'(bus.ext_gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d_stall", i),
          32'(bus.core_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d_we", i),
          32'(bus.mem_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_addr", i),
          bus.mem_addr, vecs[i].addr);
      chk($sformatf("v%0d_wdata", i),
          bus.mem_wdata, vecs[i].wdata);
      tick();
      idle();
      tick();
    end

    // Readbacks of table writes
    drv(1, 0, 0, 0, 32'h20, 0, 0, 0);
    tick();
    chk("rb_0x20", bus.core_rdata, 32'h1234);
    drv(1, 0, 0, 0, 32'h40, 0, 0, 0);
    tick();
    chk("rb_0x40", bus.core_rdata, 32'h55);
    idle();
    tick();

    // Core load latency
    drv(1, 0, 0, 0, 32'h10, 0, 0, 0);
    #1;
    chk("ld_addr",  bus.mem_addr,          32'h10);
    chk("ld_stall", 32'(bus.core_stall),   0);
    tick();
    chk("ld_rdata", bus.core_rdata,        32'hDEADBEEF);
    chk("ld_rvalid", 32'(bus.ext_rvalid),  0);
    idle();
    tick();

    // Starvation bound
    drv(1, 0, 1, 1, 32'h18, 0, 32'h2C, 32'hBEEF);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("stv_c%0d_gnt", c),
          32'(bus.ext_gnt), 0);
      chk($sformatf("stv_c%0d_stall", c),
          32'(bus.core_stall), 0);
      tick();
    end
    #1;
    chk("stv_c4_cnt",   32'(dut.starve_cnt),  4);
    chk("stv_c4_gnt",   32'(bus.ext_gnt),     1);
    chk("stv_c4_stall", 32'(bus.core_stall),  1);
    chk("stv_c4_addr",  bus.mem_addr,         32'h2C);
    tick();
    drv(1, 0, 0, 0, 32'h18, 0, 0, 0);
    #1;
    chk("stv_c5_stall", 32'(bus.core_stall),  0);
    chk("stv_c5_cnt",   32'(dut.starve_cnt),  0);
    chk("stv_c5_addr",  bus.mem_addr,         32'h18);
    idle();
    tick();
    drv(1, 0, 0, 0, 32'h2C, 0, 0, 0);
    tick();
    chk("stv_rb", bus.core_rdata, 32'hBEEF);
    idle();
    tick();

    // Ext read return then core load
    drv(0, 0, 1, 0, 0, 0, 32'h30, 0);
    #1;
    chk("er_gnt", 32'(bus.ext_gnt), 1);
    tick();
    drv(1, 0, 0, 0, 32'h10, 0, 0, 0);
    #1;
    chk("er_rvalid1", 32'(bus.ext_rvalid), 1);
    chk("er_rdata",   bus.ext_rdata,       32'hCAFE);
    tick();
    chk("er_rvalid2", 32'(bus.ext_rvalid), 0);
    chk("er_core",    bus.core_rdata,      32'hDEADBEEF);
    idle();
    tick();

    // Reset drops a pending ext read return
    drv(0, 0, 1, 0, 0, 0, 32'h24, 0);
    tick();
    rst = 1'b1;
    drv(0, 0, 1, 1, 0, 0, 32'h24, 32'h77);
    #1;
    chk("rr_rvalid", 32'(bus.ext_rvalid), 0);
    chk("rr_we",     32'(bus.mem_we),     0);
    chk("rr_gnt",    32'(bus.ext_gnt),    0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rr_rvalid2", 32'(bus.ext_rvalid), 0);
    tick();

    // Reset clears a partial starvation count
    drv(1, 0, 1, 0, 32'h18, 0, 32'h30, 0);
    tick();
    tick();
    chk("sr_cnt2", 32'(dut.starve_cnt), 2);
    rst = 1'b1;
    tick();
    chk("sr_cnt0", 32'(dut.starve_cnt), 0);
    rst = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
